// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the serial ALU add path.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int NIB       = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple-carry slice.
module adder_slice4
   import alu_pkg::*;
(
   input  logic [NIB-1:0] x,
   input  logic [NIB-1:0] y,
   input  logic           ci,
   output logic [NIB-1:0] s,
   output logic           co
);

   logic c;

   always_comb begin
      s = '0;
      c = ci;
      for (int i = 0; i < NIB; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract, one nibble per clock through a single 4-bit slice.
module nibble_serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIBBLES = WIDTH / NIB;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_width_chk
      $error("nibble_serial_adder: WIDTH must be a nonzero multiple of 4");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
   logic [IDXW-1:0]  idx;
   logic             carry, a_msb, b_msb;
   logic             ovf_q, zero_q;
   logic [NIB-1:0]   slice_s;
   logic             slice_co;
   logic             accept, last;

   adder_slice4 u_slice (
      .x  (a_sh[NIB-1:0]),
      .y  (b_sh[NIB-1:0]),
      .ci (carry),
      .s  (slice_s),
      .co (slice_co)
   );

   // New nibble enters at the top; after NIBBLES shifts it is LSB-aligned.
   if (NIBBLES == 1) begin : g_one
      assign sum_nxt = slice_s;
   end else begin : g_many
      assign sum_nxt = {slice_s, sum_sh[WIDTH-1:NIB]};
   end

   assign accept = in_valid & in_ready;
   assign last   = (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            in_ready = rst_n;
            if (in_valid & rst_n) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= op_sub ? ~b : b;
         carry <= op_sub;
         idx   <= '0;
         a_msb <= a[WIDTH-1];
         b_msb <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (state == S_RUN) begin
         a_sh   <= a_sh >> NIB;
         b_sh   <= b_sh >> NIB;
         sum_sh <= sum_nxt;
         carry  <= slice_co;
         idx    <= idx + 1'b1;
         // Flags are frozen with the final nibble so they hold through DONE.
         if (last) begin
            zero_q <= (sum_nxt == '0);
            ovf_q  <= (a_msb == b_msb) & (sum_nxt[WIDTH-1] != a_msb);
         end
      end
   end

   assign sum  = sum_sh;
   assign cout = carry;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a word-level reference model.
module tb_nibble_serial_adder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, ovf, zero;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_bad = 0;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Word-level result: {zero, ovf, cout, sum}
   function automatic logic [W+2:0] golden(input logic sub,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      longint       sx, sy, r;
      logic [W:0]   wide;
      logic [W-1:0] s;
      logic         c, o;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = sub ? sx - sy : sx + sy;
      o  = (longint'(int'(r)) != r);
      wide = {1'b0, x} + {1'b0, y};
      s  = sub ? x - y : x + y;
      c  = sub ? (x >= y) : wide[W];
      return {(s == '0), o, c, s};
   endfunction

   int             m_left;
   logic           m_valid;
   logic [W+2:0]   m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left  <= 0;
         m_valid <= 1'b0;
         m_res   <= '0;
      end else if (m_valid) begin
         if (out_ready) m_valid <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_valid <= 1'b1;
      end else if (in_valid) begin
         m_left <= W / 4;
         m_res  <= golden(op_sub, a, b);
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready", W'(in_ready), W'(rst_n && !m_valid && m_left == 0));
      chk("out_valid", W'(out_valid), W'(m_valid));
      if (!rst_n) begin
         chk("rst_sum", sum, '0);
         chk("rst_flags", W'({cout, ovf, zero}), '0);
      end else if (m_valid) begin
         chk("sum", sum, m_res[W-1:0]);
         chk("cout", W'(cout), W'(m_res[W]));
         chk("ovf", W'(ovf), W'(m_res[W+1]));
         chk("zero", W'(zero), W'(m_res[W+2]));
      end
   end

   task automatic run_op(input logic sub, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] es,
                         input logic ec, input logic eo, input logic ez);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      op_sub   = sub;
      a        = x;
      b        = y;
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_sub   = ~sub;
      a        = $urandom;
      b        = $urandom;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", W'(n), W'(8));
      chk("lit_sum", sum, es);
      chk("lit_cout", W'(cout), W'(ec));
      chk("lit_ovf", W'(ovf), W'(eo));
      chk("lit_zero", W'(zero), W'(ez));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle_after", W'({in_ready, out_valid}), W'(2'b10));
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("reset_ready", W'(in_ready), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op(1'b0, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 0, 0, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
      run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0);
      run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0);
      run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0);
      run_op(1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1, 0, 1);

      // Backpressure in DONE with an intruding operand pulse.
      @(negedge clk);
      in_valid = 1'b1;
      op_sub   = 1'b0;
      a        = 32'h0000_0100;
      b        = 32'h0000_0200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = (i == 1);
         a        = 32'hDEAD_0000;
         b        = 32'h0000_BEEF;
         chk("bp_sum", sum, 32'h0000_0300);
         chk("bp_hs", W'({in_ready, out_valid}), W'(2'b01));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release", W'({in_ready, out_valid}), W'(2'b10));
      repeat (12) @(posedge clk);
      #1;
      chk("bp_no_capture", W'(out_valid), '0);

      // out_ready held high: exactly one handshake.
      out_ready = 1'b1;
      run_op(1'b0, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_ready", W'(out_valid), '0);
      out_ready = 1'b0;

      // Reset during the third RUN cycle.
      @(negedge clk);
      in_valid = 1'b1;
      op_sub   = 1'b0;
      a        = 32'hAAAA_0000;
      b        = 32'h0000_0001;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", W'(out_valid), '0);
      chk("abort_sum", sum, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("abort_quiet", W'(out_valid), '0);
      run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
